// File: rtl/cnt_mon_pkg.sv
// Shared types and constants for the count-stream monitor.
// State encodings and event counter width.
package cnt_mon_pkg;

  localparam int CTR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

endpackage

// File: rtl/m_sat_cnt8.sv
// Saturating event counter; sticks at all-ones.
// Synchronous active-high reset.
module m_sat_cnt8
  import cnt_mon_pkg::*;
(
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_inc,
  output logic [CTR_W-1:0] w_val
);

  logic [CTR_W-1:0] val_q;
  logic [CTR_W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (w_inc && (val_q != '1)) begin
      val_d = val_q + CTR_W'(1);
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign w_val = val_q;

endmodule

// File: rtl/m_cnt_monitor.sv
// Monitors a free-running counter stream: locks, flags wraps/errors.
// CNT_MON_STICKY_ERR_EN makes ERROR absorbing with w_err held high.
module m_cnt_monitor
  import cnt_mon_pkg::*;
#(
  parameter int LOCK_N = 2,
  parameter int CNT_W  = 2
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic [CNT_W-1:0] w_cnt,
  input  logic             w_en,
  output logic             w_locked,
  output logic             w_wrap,
  output logic             w_err,
  output logic [CTR_W-1:0] w_wraps,
  output logic [CTR_W-1:0] w_errs,
  output logic [1:0]       w_state
);

  localparam int RUN_W = 4;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic             wrap_inc;
  logic             err_inc;

  logic             good;
  logic             at_max;
  logic [CNT_W-1:0] prev_inc;
  logic [RUN_W-1:0] run_inc;

  assign prev_inc = prev_q + CNT_W'(1);
  assign good     = (w_cnt == prev_inc);
  assign at_max   = (prev_q == '1);
  assign run_inc  = run_q + RUN_W'(1);

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    run_d    = run_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    wrap_inc = 1'b0;
    err_inc  = 1'b0;
    if (w_en) begin
      prev_d = w_cnt;
      unique case (1'b1)
        state_q == ST_IDLE: begin
          run_d   = '0;
          state_d = ST_SYNC;
        end
        state_q == ST_SYNC: begin
          if (good) begin
            run_d = run_inc;
            if (run_inc == RUN_W'(LOCK_N)) begin
              state_d = ST_LOCKED;
            end
          end else begin
            run_d = '0;
          end
        end
        state_q == ST_LOCKED: begin
          if (!good) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            err_inc = 1'b1;
          end else if (at_max) begin
            wrap_d   = 1'b1;
            wrap_inc = 1'b1;
          end
        end
        state_q == ST_ERROR: begin
`ifdef CNT_MON_STICKY_ERR_EN
          state_d = ST_ERROR;
`else
          run_d   = '0;
          state_d = ST_SYNC;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef CNT_MON_STICKY_ERR_EN
    // Held high for every cycle spent in ERROR.
    err_d = (state_d == ST_ERROR);
`endif
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q  <= ST_IDLE;
      prev_q   <= '0;
      run_q    <= '0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      run_q    <= run_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  m_sat_cnt8 u_wraps (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .w_inc (wrap_inc),
    .w_val (w_wraps)
  );

  m_sat_cnt8 u_errs (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .w_inc (err_inc),
    .w_val (w_errs)
  );

  assign w_locked = locked_q;
  assign w_wrap   = wrap_q;
  assign w_err    = err_q;
  assign w_state  = state_q;

endmodule

// File: tb/tb_m_cnt_monitor.sv
// Randomized bench for m_cnt_monitor against a behavioural model.
// Honours CNT_MON_STICKY_ERR_EN the same way as the design.
module tb_m_cnt_monitor;

  localparam int LOCK_N = 2;
  localparam int CNT_W  = 2;
  localparam int M      = 1 << CNT_W;

  logic             w_clk = 1'b0;
  logic             w_rst = 1'b0;
  logic [CNT_W-1:0] w_cnt = '0;
  logic             w_en  = 1'b0;
  logic             w_locked;
  logic             w_wrap;
  logic             w_err;
  logic [7:0]       w_wraps;
  logic [7:0]       w_errs;
  logic [1:0]       w_state;

  int total = 0;
  int bad   = 0;

  // model: 0 idle, 1 sync, 2 locked, 3 error
  int m_st, m_prev, m_run;
  int m_wraps, m_errs;
  bit m_wrap, m_err;
  bit sticky;

  m_cnt_monitor #(.LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut (
    .w_clk    (w_clk),
    .w_rst    (w_rst),
    .w_cnt    (w_cnt),
    .w_en     (w_en),
    .w_locked (w_locked),
    .w_wrap   (w_wrap),
    .w_err    (w_err),
    .w_wraps  (w_wraps),
    .w_errs   (w_errs),
    .w_state  (w_state)
  );

  always #5 w_clk = ~w_clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit e, input int c);
    bit good;
    m_wrap = 0;
    m_err  = 0;
    if (r) begin
      m_st = 0; m_prev = 0; m_run = 0;
      m_wraps = 0; m_errs = 0;
    end else if (e) begin
      good = (c == (m_prev + 1) % M);
      case (m_st)
        0: begin m_st = 1; m_run = 0; end
        1: begin
          if (!good) m_run = 0;
          else begin
            m_run++;
            if (m_run == LOCK_N) m_st = 2;
          end
        end
        2: begin
          if (!good) begin
            m_st = 3; m_err = 1;
            if (m_errs < 255) m_errs++;
          end else if (m_prev == M - 1) begin
            m_wrap = 1;
            if (m_wraps < 255) m_wraps++;
          end
        end
        default: begin
          if (!sticky) begin m_st = 1; m_run = 0; end
        end
      endcase
      m_prev = c;
    end
    if (sticky && m_st == 3) m_err = 1;
  endtask

  task automatic cmp_all();
    chk("locked", int'(w_locked), int'(m_st == 2));
    chk("wrap",   int'(w_wrap),   int'(m_wrap));
    chk("err",    int'(w_err),    int'(m_err));
    chk("wraps",  int'(w_wraps),  m_wraps);
    chk("errs",   int'(w_errs),   m_errs);
    chk("state",  int'(w_state),  m_st);
  endtask

  task automatic step(input bit r, input bit e, input int c);
    w_rst = r;
    w_en  = e;
    w_cnt = CNT_W'(c);
    @(posedge w_clk);
    model(r, e, c);
    @(negedge w_clk);
    cmp_all();
  endtask

  initial begin
    int c;
    bit e;
`ifdef CNT_MON_STICKY_ERR_EN
    sticky = 1;
`else
    sticky = 0;
`endif
    model(1, 0, 0);
    @(negedge w_clk);
    step(1, 1, 1);
    step(1, 0, 0);
    chk("rst_state", int'(w_state), 0);
    chk("rst_locked", int'(w_locked), 0);
    chk("rst_wraps", int'(w_wraps), 0);

    // lock then wrap
    step(0, 1, 0);
    step(0, 1, 1);
    chk("no_lock_yet", int'(w_locked), 0);
    step(0, 1, 2);
    chk("lock_rise", int'(w_locked), 1);
    step(0, 1, 3);
    step(0, 1, 0);
    chk("wrap_pulse", int'(w_wrap), 1);
    step(0, 1, 1);
    chk("wrap_drop", int'(w_wrap), 0);
    chk("wraps_1", int'(w_wraps), 1);
    chk("errs_0", int'(w_errs), 0);

    // bad step while locked
    step(0, 1, 2);
    step(0, 1, 0);
    chk("err_pulse", int'(w_err), 1);
    chk("errs_1", int'(w_errs), 1);
    chk("err_state", int'(w_state), 3);
    step(0, 1, 1);
`ifdef CNT_MON_STICKY_ERR_EN
    chk("sticky_state", int'(w_state), 3);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, (2 + i) % M);
      chk("sticky_err", int'(w_err), 1);
      chk("sticky_st", int'(w_state), 3);
    end
    chk("sticky_errs", int'(w_errs), 1);
`else
    chk("resync_state", int'(w_state), 1);
    chk("err_drop", int'(w_err), 0);
`endif
    step(1, 1, 0);
    chk("rst_ret", int'(w_state), 0);

    // enable gaps while counting
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 2);
    step(0, 1, 3);
    step(0, 0, 0);
    chk("gap_wrap0", int'(w_wrap), 0);
    chk("gap_err0", int'(w_err), 0);
    step(0, 0, 1);
    chk("gap_wrap1", int'(w_wrap), 0);
    chk("gap_err1", int'(w_err), 0);
    step(0, 1, 2);
    chk("gap_err", int'(w_err), 1);

    // saturation
    step(1, 0, 0);
    for (int i = 0; i < 1100; i++) step(0, 1, i % M);
    chk("wraps_sat", int'(w_wraps), 255);
    for (int i = 1100; i < 1110; i++) step(0, 1, i % M);
    chk("wraps_hold", int'(w_wraps), 255);

    // reset mid-lock
    for (int i = 3; i < 7; i++) step(0, 1, i % M);
    chk("pre_rst_lock", int'(w_locked), 1);
    step(1, 1, 3);
    chk("mid_rst_st", int'(w_state), 0);
    chk("mid_rst_wraps", int'(w_wraps), 0);
    chk("mid_rst_lock", int'(w_locked), 0);
    step(0, 1, 0);
    step(0, 1, 1);
    chk("relock_wait", int'(w_locked), 0);
    step(0, 1, 2);
    chk("relock", int'(w_locked), 1);

    // random traffic
    c = 3;
    for (int i = 0; i < 2000; i++) begin
      c = (c + 1) % M;
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        step(0, e, int'($urandom_range(0, M - 1)));
      end else if ($urandom_range(0, 199) == 0) begin
        step(1, e, c);
      end else begin
        step(0, e, c);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m_cnt_monitor.md
M_CNT_MONITOR -- requirements
Module: m_cnt_monitor

Interface
REQ-001 Parameter LOCK_N, default 2, SHALL set the number of consecutive good increments required to lock (legal range 1..15).
REQ-002 Parameter CNT_W, default 2, SHALL set the width of the monitored count.
REQ-003 w_clk  in  1  the single clock; all state SHALL change on its positive edge only.
REQ-004 w_rst  in  1  synchronous, active-high reset, sampled on the w_clk positive edge.
REQ-005 w_cnt  in  CNT_W  count stream from the upstream free-running counter.
REQ-006 w_en  in  1  sample enable; w_cnt is examined only on edges where w_en=1.
REQ-007 w_locked  out  1  high while the FSM is in LOCKED.
REQ-008 w_wrap  out  1  one-cycle pulse for a wrap (max to 0) seen while LOCKED.
REQ-009 w_err  out  1  one-cycle pulse for a bad step seen while LOCKED.
REQ-010 w_wraps  out  8  saturating count of w_wrap pulses.
REQ-011 w_errs  out  8  saturating count of w_err pulses.
REQ-012 w_state  out  2  current FSM state encoding.

Function
REQ-013 All outputs SHALL be registered, and SHALL reflect a sample in the cycle after the edge that took it (1-cycle latency).
REQ-014 A good step SHALL mean that sample equals (r_prev + 1) mod 2^CNT_W, where r_prev is the last enabled sample; any other value SHALL be a bad step.
REQ-015 On every enabled edge r_prev SHALL load w_cnt, including after a bad step.
REQ-016 FSM states SHALL be IDLE=0, SYNC=1, LOCKED=2 and ERROR=3.
REQ-017 IDLE: on an enabled edge, the FSM SHALL store the sample, clear the run count, and go to SYNC; no comparison is made.
REQ-018 SYNC: a good step SHALL increment the run count, and on reaching LOCK_N the FSM SHALL go to LOCKED.
REQ-019 SYNC: a bad step SHALL clear the run count and keep the FSM in SYNC, with no w_err pulse.
REQ-020 LOCKED: a good step SHALL keep the FSM in LOCKED.
REQ-021 LOCKED: a good step from max to 0 SHALL also pulse w_wrap and increment w_wraps.
REQ-022 LOCKED: a bad step SHALL pulse w_err, increment w_errs, and move the FSM to ERROR.
REQ-023 ERROR: on the next enabled edge, the FSM SHALL clear the run count and go to SYNC.
REQ-024 With w_en=0, state, r_prev, run count and counters SHALL hold, and w_wrap and w_err SHALL be 0.
REQ-025 w_wraps and w_errs SHALL stop at 255 and never wrap.
REQ-026 Wrap and error are mutually exclusive per sample, so at most one pulse SHALL occur per cycle.

Reset
REQ-027 On an edge with w_rst=1 the block SHALL enter IDLE, taking priority over w_en.
REQ-028 Reset SHALL clear r_prev, the run count, w_locked, w_wrap, w_err, w_wraps and w_errs to 0, and set w_state to 0.
REQ-029 Reset asserted mid-run SHALL discard all history, so the first enabled sample after reset only primes r_prev.

Configuration
REQ-030 Macro CNT_MON_STICKY_ERR_EN SHALL select how the ERROR state behaves.
REQ-031 With CNT_MON_STICKY_ERR_EN defined, ERROR SHALL be absorbing until w_rst, and w_err SHALL stay high while in ERROR.
REQ-032 With CNT_MON_STICKY_ERR_EN defined, w_errs SHALL count one per entry to ERROR.
REQ-033 Without CNT_MON_STICKY_ERR_EN, the block SHALL follow REQ-022 and REQ-023 (w_err is a pulse and the FSM resynchronises).

Structure
REQ-034 Shared package cnt_mon_pkg SHALL hold the state encodings (ST_IDLE, ST_SYNC, ST_LOCKED, ST_ERROR) and the 8-bit counter width constant.
REQ-035 The 8-bit saturating counters SHALL be one sub-module, m_sat_cnt8 (inputs w_clk, w_rst, w_inc; output 8-bit value), instantiated twice.
REQ-036 The FSM, r_prev and the run count SHALL live in m_cnt_monitor.

Verification
REQ-037 Reset, then w_en=1 with w_cnt 0,1,2,3,0,1 -> w_locked rises the cycle after sample 2; w_wrap pulses once after sample 0; w_wraps=1; w_errs=0.
REQ-038 While locked, inject w_cnt sequence 1,2,0 -> w_err pulses once and w_errs=1; w_state=3, then w_state=1 after the next enabled sample (non-sticky build).
REQ-039 Same stimulus with CNT_MON_STICKY_ERR_EN defined -> w_state remains 3 and w_err remains 1 through 10 further good samples; w_rst returns w_state to 0.
REQ-040 Locked stream with w_en toggling 1,0,0,1 while w_cnt keeps counting -> a bad step is detected only if the enabled samples are non-consecutive values; holds verified with w_wrap=0 and w_err=0 on disabled cycles.
REQ-041 Run 1100 clean cycles while locked -> w_wraps saturates at 255 and stays 255.
REQ-042 Assert w_rst for one cycle during LOCKED at w_cnt=2 -> all outputs 0 next cycle; relock requires 1 priming sample plus LOCK_N good steps.
